// File: rtl/trig_sched_pkg.sv
// Shared constants for the triggered read-burst scheduler: default widths and FSM state encoding.
package trig_sched_pkg;

  localparam int unsigned AW_DEF = 12;
  localparam int unsigned LW_DEF = 8;
  localparam int unsigned GW     = 4;
  localparam int unsigned CW     = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/trig_read_sched_if.sv
// Request/acknowledge bundle between the two burst requesters and the scheduler.
interface trig_read_sched_if
  import trig_sched_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
);

  logic          req0;
  logic          req1;
  logic [AW-1:0] req0_addr;
  logic [AW-1:0] req1_addr;
  logic          ack0;
  logic          ack1;

  modport master (output req0, req1, req0_addr, req1_addr, input ack0, ack1);
  modport slave  (input req0, req1, req0_addr, req1_addr, output ack0, ack1);

endinterface

// File: rtl/trig_read_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when the grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt_c
);

  // r_ptr = 1 means requester 1 wins a tie
  logic r_ptr;

  always_comb begin
    o_gnt_c = i_req;
    if (i_req == 2'b11) begin
      o_gnt_c = r_ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= o_gnt_c[0];
    end
  end

endmodule

// File: rtl/trig_read_sched.sv
// Triggered read scheduler: grants one of two burst requests, streams consecutive
// read addresses for the latched length, then idles for the latched gap.
module trig_read_sched
  import trig_sched_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [LW-1:0]    cfg_len,
  input  logic [GW-1:0]    cfg_gap,
  trig_read_sched_if.slave rd,
  output logic             out_rena,
  output logic [AW-1:0]    out_raddr,
  output logic             busy,
  output logic             done,
  output logic             gnt_id,
  output logic [CW-1:0]    trig_cnt
);

  logic [1:0]    r_state,  w_state_nxt;
  logic [LW-1:0] r_left,   w_left_nxt;
  logic [GW-1:0] r_gap,    w_gap_nxt;
  logic [GW-1:0] r_gleft,  w_gleft_nxt;
  logic          r_rena,   w_rena_nxt;
  logic [AW-1:0] r_raddr,  w_raddr_nxt;
  logic [1:0]    r_ack,    w_ack_nxt;
  logic          r_done,   w_done_nxt;
  logic          r_busy,   w_busy_nxt;
  logic          r_gnt_id, w_gnt_id_nxt;
  logic [CW-1:0] r_cnt,    w_cnt_nxt;

  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_accept;

  assign w_req    = {rd.req1, rd.req0};
  assign w_accept = (r_state == ST_IDLE) && ena && (|w_req);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_gnt_c  (w_gnt)
  );

  // Next-state and next-output logic; r_left counts words remaining after the current one
  always_comb begin
    w_state_nxt  = r_state;
    w_left_nxt   = r_left;
    w_gap_nxt    = r_gap;
    w_gleft_nxt  = r_gleft;
    w_rena_nxt   = r_rena;
    w_raddr_nxt  = r_raddr;
    w_ack_nxt    = 2'b00;
    w_done_nxt   = 1'b0;
    w_gnt_id_nxt = r_gnt_id;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = ST_READ;
          w_ack_nxt    = w_gnt;
          w_gnt_id_nxt = w_gnt[1];
          w_raddr_nxt  = w_gnt[1] ? rd.req1_addr : rd.req0_addr;
          w_rena_nxt   = 1'b1;
          // length 0 wraps to all-ones, i.e. 2^LW words
          w_left_nxt   = cfg_len - LW'(1);
          w_gap_nxt    = cfg_gap;
          w_cnt_nxt    = r_cnt + CW'(1);
        end
      end
      ST_READ: begin
        if (r_left == '0) begin
          w_rena_nxt = 1'b0;
          w_done_nxt = 1'b1;
          if (r_gap != '0) begin
            w_state_nxt = ST_GAP;
            w_gleft_nxt = r_gap - GW'(1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_left_nxt  = r_left - LW'(1);
          w_raddr_nxt = r_raddr + AW'(1);
        end
      end
      ST_GAP: begin
        if (r_gleft == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gleft_nxt = r_gleft - GW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rena_nxt  = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_left   <= '0;
      r_gap    <= '0;
      r_gleft  <= '0;
      r_rena   <= 1'b0;
      r_raddr  <= '0;
      r_ack    <= 2'b00;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_gnt_id <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_left   <= w_left_nxt;
      r_gap    <= w_gap_nxt;
      r_gleft  <= w_gleft_nxt;
      r_rena   <= w_rena_nxt;
      r_raddr  <= w_raddr_nxt;
      r_ack    <= w_ack_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign rd.ack0   = r_ack[0];
  assign rd.ack1   = r_ack[1];
  assign out_rena  = r_rena;
  assign out_raddr = r_raddr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign gnt_id    = r_gnt_id;
  assign trig_cnt  = r_cnt;

endmodule

// File: tb/tb_trig_read_sched.sv
// Scoreboard bench for trig_read_sched: the stimulus side predicts each burst at
// transaction level, a negedge monitor checks grants, addresses, lengths and gaps.
module tb_trig_read_sched;

  localparam int unsigned AW = 12;
  localparam int unsigned LW = 8;
  localparam int LIM = 2000;

  typedef struct {
    int id;
    int addr;
    int n;
    int gap;
    int cnt;
  } burst_t;

  logic          clk;
  logic          rst;
  logic          ena;
  logic [LW-1:0] cfg_len;
  logic [3:0]    cfg_gap;
  logic          out_rena;
  logic [AW-1:0] out_raddr;
  logic          busy;
  logic          done;
  logic          gnt_id;
  logic [15:0]   trig_cnt;

  int     checks    = 0;
  int     errors    = 0;
  int     ack_cnt   = 0;
  int     done_cnt  = 0;
  int     exp_done  = 0;
  int     exp_cnt   = 0;
  int     last_id   = 1;
  bit     exact_gap = 1'b0;
  burst_t exp_q[$];

  trig_read_sched_if #(.AW(AW)) rd_if ();

  trig_read_sched #(.AW(AW), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cfg_len   (cfg_len),
    .cfg_gap   (cfg_gap),
    .rd        (rd_if),
    .out_rena  (out_rena),
    .out_raddr (out_raddr),
    .busy      (busy),
    .done      (done),
    .gnt_id    (gnt_id),
    .trig_cnt  (trig_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int got, input int want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_eq(input string name, input int got, input int want);
    chk(got == want, name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input bit v);
    if (id == 0) rd_if.req0 = v;
    else if (id == 1) rd_if.req1 = v;
  endtask

  task automatic set_addr(input int id, input int a);
    if (id == 0) rd_if.req0_addr = AW'(a);
    else rd_if.req1_addr = AW'(a);
  endtask

  // Expected burst: N = len (0 means 256), addresses a, a+1, ... mod 4096
  task automatic push_exp(input int id, input int a, input int len, input int gap);
    burst_t b;
    exp_cnt = (exp_cnt + 1) % 65536;
    b.id   = id;
    b.addr = a;
    b.n    = (len == 0) ? 256 : len;
    b.gap  = gap;
    b.cnt  = exp_cnt;
    exp_q.push_back(b);
    exp_done++;
    last_id = id;
  endtask

  task automatic wait_ack(output int id, output int cyc);
    cyc = 0;
    id  = -1;
    do begin
      tick();
      cyc++;
    end while (!(rd_if.ack0 || rd_if.ack1) && cyc < LIM);
    if (rd_if.ack0) id = 0;
    else if (rd_if.ack1) id = 1;
    else chk(1'b0, "ack_timeout", cyc, LIM);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < LIM);
    if (!done) chk(1'b0, "done_timeout", cyc, LIM);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while ((busy || out_rena) && c < LIM);
    if (c >= LIM) chk(1'b0, "idle_timeout", c, LIM);
  endtask

  task automatic scramble_cfg();
    cfg_len = LW'($urandom);
    cfg_gap = 4'($urandom);
  endtask

  task automatic single(input int id, input int a, input int len, input int gap);
    int g;
    int c;
    cfg_len = LW'(len);
    cfg_gap = 4'(gap);
    set_addr(id, a);
    push_exp(id, a, len, gap);
    set_req(id, 1'b1);
    wait_ack(g, c);
    chk_eq("single_ack_id", g, id);
    set_req(id, 1'b0);
    scramble_cfg();
  endtask

  task automatic pair(input int a0, input int a1, input int len, input int gap);
    int w;
    int g;
    int c;
    w = (last_id == 0) ? 1 : 0;
    cfg_len = LW'(len);
    cfg_gap = 4'(gap);
    set_addr(0, a0);
    set_addr(1, a1);
    push_exp(w, (w == 0) ? a0 : a1, len, gap);
    push_exp(1 - w, (w == 0) ? a1 : a0, len, gap);
    rd_if.req0 = 1'b1;
    rd_if.req1 = 1'b1;
    wait_ack(g, c);
    set_req(g, 1'b0);
    wait_ack(g, c);
    set_req(g, 1'b0);
    rd_if.req0 = 1'b0;
    rd_if.req1 = 1'b0;
    scramble_cfg();
  endtask

  // Monitor: samples at negedge, pops one expected burst per ack
  initial begin : monitor
    burst_t cur;
    bit active;
    int idx;
    int low;
    int prev_gap;
    bit prev_busy;
    bit rst_prev;
    active = 1'b0; idx = 0; low = 0; prev_gap = -1; prev_busy = 1'b0; rst_prev = 1'b0;
    cur = '{id: 0, addr: 0, n: 0, gap: 0, cnt: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        rst_prev = 1'b1;
      end else if (rst_prev) begin
        rst_prev = 1'b0;
        chk_eq("rst_rena", int'(out_rena), 0);
        chk_eq("rst_raddr", int'(out_raddr), 0);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_done", int'(done), 0);
        chk_eq("rst_ack", int'({rd_if.ack1, rd_if.ack0}), 0);
        chk_eq("rst_gnt_id", int'(gnt_id), 0);
        chk_eq("rst_trig_cnt", int'(trig_cnt), 0);
        active = 1'b0; idx = 0; low = 0; prev_gap = -1; prev_busy = busy;
      end else begin
        if (rd_if.ack0 || rd_if.ack1) begin
          ack_cnt++;
          chk(!(rd_if.ack0 && rd_if.ack1), "ack_onehot", int'({rd_if.ack1, rd_if.ack0}), 1);
          chk(!prev_busy, "ack_outside_idle", int'(prev_busy), 0);
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_ack", int'(rd_if.ack1), -1);
          end else begin
            cur = exp_q.pop_front();
            active = 1'b1;
            idx = 0;
            chk_eq("ack_id", int'(rd_if.ack1), cur.id);
            chk_eq("gnt_id", int'(gnt_id), cur.id);
            chk_eq("trig_cnt", int'(trig_cnt), cur.cnt);
            if (prev_gap >= 0) begin
              if (exact_gap) chk_eq("idle_gap", low, prev_gap + 1);
              else chk(low >= prev_gap + 1, "idle_gap_min", low, prev_gap + 1);
            end
          end
        end
        if (out_rena) begin
          low = 0;
          if (!active || idx >= cur.n) begin
            chk(1'b0, "rena_extra", idx, cur.n);
          end else begin
            chk_eq("raddr", int'(out_raddr), (cur.addr + idx) % 4096);
            idx++;
          end
        end else begin
          low++;
          if (active) chk(done, "rena_hole", idx, cur.n);
        end
        if (done) begin
          if (!active) begin
            chk(1'b0, "done_unexpected", 1, 0);
          end else begin
            chk_eq("burst_words", idx, cur.n);
            chk_eq("done_busy", int'(busy), int'(cur.gap != 0));
            prev_gap = cur.gap;
            active = 1'b0;
            done_cnt++;
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : stim
    int g;
    int c;
    int a;
    rst = 1'b1;
    ena = 1'b0;
    cfg_len = '0;
    cfg_gap = '0;
    rd_if.req0 = 1'b0;
    rd_if.req1 = 1'b0;
    rd_if.req0_addr = '0;
    rd_if.req1_addr = '0;
    repeat (3) tick();

    // Basic burst; request is already up when reset drops
    ena = 1'b1;
    cfg_len = LW'(4);
    cfg_gap = 4'(0);
    set_addr(0, 'h100);
    push_exp(0, 'h100, 4, 0);
    rd_if.req0 = 1'b1;
    rst = 1'b0;
    wait_ack(g, c);
    rd_if.req0 = 1'b0;
    chk_eq("first_ack_cycle", c, 1);
    chk_eq("first_ack_id", g, 0);
    scramble_cfg();
    wait_done(c);
    chk_eq("first_done_cycle", c, 4);

    // Address wrap at the top of the space
    single(1, 'hFFE, 4, 0);
    wait_done(c);
    chk_eq("wrap_done_cycle", c, 4);

    // Both held: strict alternation and exact gap+1 idle cycles
    cfg_len = LW'(2);
    cfg_gap = 4'(3);
    set_addr(0, 'h200);
    set_addr(1, 'h300);
    push_exp(0, 'h200, 2, 3);
    push_exp(1, 'h300, 2, 3);
    push_exp(0, 'h200, 2, 3);
    push_exp(1, 'h300, 2, 3);
    rd_if.req0 = 1'b1;
    rd_if.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(g, c);
      chk_eq("alt_grant", g, k % 2);
      if (k == 0) begin
        tick();
        exact_gap = 1'b1;
      end
    end
    rd_if.req0 = 1'b0;
    rd_if.req1 = 1'b0;
    tick();
    exact_gap = 1'b0;
    wait_done(c);

    // Length 0 means 256 words
    single(0, 'h010, 0, 1);
    wait_done(c);
    chk_eq("len0_words", c, 256);

    // Reset on the third word of an 8-word burst
    wait_idle();
    single(0, 'h0A0, 8, 0);
    tick();
    tick();
    rst = 1'b1;
    exp_cnt = 0;
    last_id = 1;
    exp_done--;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk_eq("post_rst_trig_cnt", int'(trig_cnt), 0);
    chk_eq("post_rst_busy", int'(busy), 0);

    // Enable dropped mid-burst: burst completes, pending request waits
    single(0, 'h040, 8, 2);
    ena = 1'b0;
    set_addr(1, 'h777);
    rd_if.req1 = 1'b1;
    wait_done(c);
    chk_eq("ena_off_burst_len", c, 8);
    a = ack_cnt;
    repeat (30) tick();
    chk_eq("ena_off_no_ack", ack_cnt, a);
    chk_eq("ena_off_idle", int'(busy), 0);
    cfg_len = LW'(3);
    cfg_gap = 4'(0);
    push_exp(1, 'h777, 3, 0);
    ena = 1'b1;
    wait_ack(g, c);
    rd_if.req1 = 1'b0;
    chk_eq("ena_on_ack", g, 1);
    wait_done(c);

    // Request withdrawn before its grant is dropped
    single(0, 'h500, 10, 0);
    rd_if.req1_addr = AW'('h123);
    rd_if.req1 = 1'b1;
    tick();
    a = ack_cnt;
    repeat (3) tick();
    rd_if.req1 = 1'b0;
    wait_done(c);
    repeat (5) tick();
    chk_eq("dropped_req_no_ack", ack_cnt, a);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int len;
      int gap;
      len = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 20));
      gap = int'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 2) begin
        pair(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), len, gap);
      end else begin
        single(int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)), len, gap);
      end
    end

    wait_idle();
    repeat (3) tick();
    chk_eq("exp_q_empty", exp_q.size(), 0);
    chk_eq("done_count", done_cnt, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_read_sched.md
TRIG_READ_SCHED -- requirements
Module: trig_read_sched

Interface
REQ-001 The block SHALL have parameter AW, default 12, memory read-address width.
REQ-002 The block SHALL have parameter LW, default 8, burst-length field width.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL have port ena, input, 1, scheduler enable; gates new grants only.
REQ-006 The block SHALL have port cfg_len, input, LW, burst length in words; 0 means 2^LW.
REQ-007 The block SHALL have port cfg_gap, input, 4, idle cycles inserted after each burst.
REQ-008 The block SHALL have ports req0/req1, input, 1 each, read-burst requests, held until acked.
REQ-009 The block SHALL have ports req0_addr/req1_addr, input, AW each, burst start address.
REQ-010 The block SHALL have ports ack0/ack1, output, 1 each, one-cycle grant pulse.
REQ-011 The block SHALL have port out_rena, output, 1, memory read enable.
REQ-012 The block SHALL have port out_raddr, output, AW, memory read address.
REQ-013 The block SHALL have ports busy (1), done (1), gnt_id (1) and trig_cnt (16), all outputs: burst/gap active, end-of-burst pulse, last granted requester, grant count.

Function
REQ-014 The FSM SHALL have states IDLE, READ and GAP.
REQ-015 In IDLE with ena=1 and any req high at edge E, the block SHALL, at E, grant one requester, pulse its ack, set gnt_id, load out_raddr=its start address, set out_rena=1, latch cfg_len/cfg_gap and enter READ.
REQ-016 Arbitration SHALL be two-way round-robin: when both requests are high, the requester not granted last wins; after reset req0 has priority.
REQ-017 In READ, each edge SHALL advance out_raddr by 1 modulo 2^AW (4095 -> 0) until exactly N words are issued (N = latched length); out_rena SHALL be high for exactly N consecutive cycles.
REQ-018 On the edge after the last word, the block SHALL drive out_rena=0, pulse done for one cycle and enter GAP when gap>0, otherwise IDLE.
REQ-019 GAP SHALL last exactly the latched gap cycles and then enter IDLE; out_rena SHALL stay low for at least gap+1 cycles between bursts.
REQ-020 busy SHALL be high in READ and GAP and low in IDLE.
REQ-021 trig_cnt SHALL increment by 1 on each grant and wrap from 0xFFFF to 0.
REQ-022 A request deasserted before its ack SHALL be dropped, with no ack and no burst.
REQ-023 Requests arriving in READ/GAP SHALL wait; ack SHALL never be issued outside IDLE.
REQ-024 Deasserting ena mid-burst SHALL let the current burst and gap complete, after which no grant is issued while ena=0.
REQ-025 Changes to cfg_len/cfg_gap after a grant SHALL NOT affect the burst in progress.

Reset
REQ-026 With rst=1 at an edge, the block SHALL set state IDLE, out_rena=0, out_raddr=0, ack0=ack1=0, done=0, busy=0, gnt_id=0, trig_cnt=0, and the round-robin pointer to favour req0.
REQ-027 Reset mid-burst SHALL abort immediately with no done pulse; the first grant is possible on the first edge with rst=0.

Structure
REQ-028 The state encoding and default AW/LW constants SHALL reside in shared package trig_sched_pkg.
REQ-029 Arbitration SHALL be a sub-module rr_arb2: 2 requests in, one-hot grant out, pointer updated on accept.

Verification
REQ-030 The bench SHALL drive req0=1, addr=0x100, cfg_len=4, gap=0 and require ack0 on edge 1, out_raddr 0x100..0x103 with out_rena high 4 cycles, done on the 5th edge and trig_cnt=1.
REQ-031 The bench SHALL drive req1 with addr=0xFFE, cfg_len=4 and require addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-032 The bench SHALL hold req0 and req1 high continuously with len=2 and gap=3, and require grants alternating 0,1,0,1, with out_rena low for 4 cycles between bursts.
REQ-033 The bench SHALL drive cfg_len=0 and require 256 consecutive out_rena cycles.
REQ-034 The bench SHALL assert rst on the 3rd word of an 8-word burst and require out_rena=0, busy=0, trig_cnt=0 the next cycle, with no done pulse.
REQ-035 The bench SHALL drop ena during a burst and require the burst to complete with no further ack while req stays high.
